// File: rtl/ddr3_strip_reader_multicam_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_strip_reader_multicam_if
// Description : Bus bundle for the multi-camera DDR3 column-strip reader.
//               Groups the command handshake, the Avalon-MM read master and
//               the output beat stream.
//               master : the strip reader (drives requests and beats)
//               slave  : the environment (command source, DDR3, pipeline)
// Ports       : start_*  command (addr, cols, cams, cam_stride, valid/ready)
//               ddr3_*   Avalon-MM burst read master
//               out_*    beat stream with camera / SOF / EOF tags
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr3_strip_reader_multicam_if #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 27,
  parameter int NUM_CAMS = 2,
  parameter int MAX_COLS = 32
);
  localparam int c_COL_W  = $clog2(MAX_COLS + 1);
  localparam int c_CAMS_W = $clog2(NUM_CAMS + 1);
  localparam int c_CAM_W  = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1;

  logic [ADDR_W-1:0]   start_addr;
  logic [c_COL_W-1:0]  start_cols;
  logic [c_CAMS_W-1:0] start_cams;
  logic [ADDR_W-1:0]   start_cam_stride;
  logic                start_valid;
  logic                start_ready;

  logic [ADDR_W-1:0]   ddr3_address;
  logic                ddr3_read;
  logic [3:0]          ddr3_burstcount;
  logic                ddr3_waitrequest;
  logic [DATA_W-1:0]   ddr3_readdata;
  logic                ddr3_readdatavalid;

  logic [DATA_W-1:0]   out_data;
  logic [c_CAM_W-1:0]  out_cam;
  logic                out_sof;
  logic                out_eof;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  start_addr, start_cols, start_cams, start_cam_stride, start_valid,
    output start_ready,
    output ddr3_address, ddr3_read, ddr3_burstcount,
    input  ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
    output out_data, out_cam, out_sof, out_eof, out_valid,
    input  out_ready
  );

  modport slave (
    output start_addr, start_cols, start_cams, start_cam_stride, start_valid,
    input  start_ready,
    input  ddr3_address, ddr3_read, ddr3_burstcount,
    output ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
    input  out_data, out_cam, out_sof, out_eof, out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_strip_reader_multicam.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_strip_reader_multicam
// Description : Column-strip DDR3 reader for N camera frames at a fixed
//               stride. Per camera the strip is walked column-major (all
//               lines of a column, then the next column). Burst reads are
//               credit-limited so the output buffer can never overflow.
// Ports       : ddr3clk        clock
//               ddr3clk_reset  synchronous active-high reset
//               bus            command / Avalon-MM read / output stream
//               busy           command active, reads outstanding or beats
//                              still buffered
//               err_flags      sticky {bad command, stray beat}
//                              (only with DDR3_STRIP_READER_ERRCHK_EN)
// Options     : DDR3_STRIP_READER_ERRCHK_EN - reject out-of-range commands
//               and flag stray beats; undefined: clamp cols/cams silently.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_strip_reader_multicam #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 27,
  parameter int NUM_CAMS    = 2,
  parameter int FRAME_LINES = 480,
  parameter int LINE_STRIDE = 48,
  parameter int MAX_COLS    = 32,
  parameter int BURST_LEN   = 1,
  parameter int OUT_DEPTH   = 64
) (
  input  wire                            ddr3clk,
  input  wire                            ddr3clk_reset,
  ddr3_strip_reader_multicam_if.master   bus,
  output logic                           busy
`ifdef DDR3_STRIP_READER_ERRCHK_EN
  ,
  output logic [1:0]                     err_flags
`endif
);

  localparam int c_COL_W  = $clog2(MAX_COLS + 1);
  localparam int c_CAMS_W = $clog2(NUM_CAMS + 1);
  localparam int c_CAM_W  = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1;
  localparam int c_LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int c_BIDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int c_PTR_W  = $clog2(OUT_DEPTH);
  localparam int c_CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int c_SUM_W  = c_CNT_W + 2;
  localparam int c_TAG_W  = c_CAM_W + 2;
  localparam int c_BUF_W  = DATA_W + c_CAM_W + 2;
  localparam logic [ADDR_W-1:0] c_COL_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] c_LINE_STEP = ADDR_W'(LINE_STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [ADDR_W-1:0]   r_addr, r_cam_base, r_col_base, r_cam_stride;
  logic [c_COL_W-1:0]  r_cols, r_col, w_cols_eff;
  logic [c_CAMS_W-1:0] r_cams, w_cams_eff;
  logic [c_CAM_W-1:0]  r_cam;
  logic [c_LINE_W-1:0] r_line;
  logic [c_CNT_W-1:0]  r_outstanding, r_level, w_inc, w_dec;
  logic [c_BIDX_W-1:0] r_beat_idx;

  logic [c_TAG_W-1:0]  r_tag_mem [OUT_DEPTH];
  logic [c_PTR_W-1:0]  r_tag_wr, r_tag_rd;
  logic [c_BUF_W-1:0]  r_buf_mem [OUT_DEPTH];
  logic [c_PTR_W-1:0]  r_buf_wr, r_buf_rd;

  logic [c_SUM_W-1:0]  w_credit_sum;
  logic [c_TAG_W-1:0]  w_tag, w_tag_new;
  logic [c_BUF_W-1:0]  w_head;
  logic w_cmd_fire, w_cmd_take, w_cmd_bad, w_credit_ok, w_read, w_accept;
  logic w_last_line, w_last_col, w_last_cam, w_first_req, w_last_req;
  logic w_beat_ok, w_beat_last, w_buf_empty, w_buf_full, w_wr, w_rd;
  logic w_sof, w_eof;

  // ---------------------------------------------------------------- command
  assign bus.start_ready = (r_state == ST_IDLE) && !ddr3clk_reset;
  assign w_cmd_fire      = bus.start_valid && bus.start_ready;

`ifdef DDR3_STRIP_READER_ERRCHK_EN
  assign w_cmd_bad = (bus.start_cols > c_COL_W'(MAX_COLS)) ||
                     (bus.start_cams > c_CAMS_W'(NUM_CAMS));
`else
  assign w_cmd_bad = 1'b0;
`endif
  assign w_cmd_take = w_cmd_fire && !w_cmd_bad;

  // Zero means one; oversize values clamp (only reachable without ERRCHK).
  always_comb begin
    w_cols_eff = bus.start_cols;
    if (bus.start_cols == '0)
      w_cols_eff = c_COL_W'(1);
    else if (bus.start_cols > c_COL_W'(MAX_COLS))
      w_cols_eff = c_COL_W'(MAX_COLS);
    w_cams_eff = bus.start_cams;
    if (bus.start_cams == '0)
      w_cams_eff = c_CAMS_W'(1);
    else if (bus.start_cams > c_CAMS_W'(NUM_CAMS))
      w_cams_eff = c_CAMS_W'(NUM_CAMS);
  end

  // ---------------------------------------------------------------- issue
  // Credit covers beats in flight plus beats already buffered, so every
  // accepted burst is guaranteed a buffer slot on return.
  assign w_credit_sum = c_SUM_W'(r_outstanding) + c_SUM_W'(r_level) +
                        c_SUM_W'(BURST_LEN);
  assign w_credit_ok  = w_credit_sum <= c_SUM_W'(OUT_DEPTH);
  assign w_read       = (r_state == ST_ISSUE) && w_credit_ok && !ddr3clk_reset;
  assign w_accept     = w_read && !bus.ddr3_waitrequest;

  assign bus.ddr3_read       = w_read;
  assign bus.ddr3_address    = r_addr;
  assign bus.ddr3_burstcount = 4'(BURST_LEN);

  assign w_last_line = r_line == c_LINE_W'(FRAME_LINES - 1);
  assign w_last_col  = r_col == (r_cols - c_COL_W'(1));
  assign w_last_cam  = c_CAMS_W'(r_cam) == (r_cams - c_CAMS_W'(1));
  assign w_first_req = (r_line == '0) && (r_col == '0);
  assign w_last_req  = w_last_line && w_last_col;
  assign w_tag_new   = {r_cam, w_first_req, w_last_req};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge ddr3clk) begin
    if (ddr3clk_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_take) w_state_next = ST_ISSUE;
      ST_ISSUE: if (w_accept && w_last_req && w_last_cam) w_state_next = ST_DRAIN;
      ST_DRAIN: if ((r_outstanding == '0) && w_buf_empty) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- walker
  // r_col_base tracks cam_base + col*BURST_LEN so no multiplier is needed.
  always_ff @(posedge ddr3clk) begin
    if (ddr3clk_reset) begin
      r_addr       <= '0;
      r_cam_base   <= '0;
      r_col_base   <= '0;
      r_cam_stride <= '0;
      r_cols       <= c_COL_W'(1);
      r_cams       <= c_CAMS_W'(1);
      r_col        <= '0;
      r_cam        <= '0;
      r_line       <= '0;
    end else if ((r_state == ST_IDLE) && w_cmd_take) begin
      r_addr       <= bus.start_addr;
      r_cam_base   <= bus.start_addr;
      r_col_base   <= bus.start_addr;
      r_cam_stride <= bus.start_cam_stride;
      r_cols       <= w_cols_eff;
      r_cams       <= w_cams_eff;
      r_col        <= '0;
      r_cam        <= '0;
      r_line       <= '0;
    end else if (w_accept) begin
      if (!w_last_line) begin
        r_line <= r_line + c_LINE_W'(1);
        r_addr <= r_addr + c_LINE_STEP;
      end else begin
        r_line <= '0;
        if (!w_last_col) begin
          r_col      <= r_col + c_COL_W'(1);
          r_col_base <= r_col_base + c_COL_STEP;
          r_addr     <= r_col_base + c_COL_STEP;
        end else begin
          r_col <= '0;
          if (!w_last_cam) begin
            r_cam      <= r_cam + c_CAM_W'(1);
            r_cam_base <= r_cam_base + r_cam_stride;
            r_col_base <= r_cam_base + r_cam_stride;
            r_addr     <= r_cam_base + r_cam_stride;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- return
  // Beats with nothing outstanding are leftovers from before a reset.
  assign w_beat_ok   = bus.ddr3_readdatavalid && (r_outstanding != '0);
  assign w_beat_last = r_beat_idx == c_BIDX_W'(BURST_LEN - 1);
  assign w_tag       = r_tag_mem[r_tag_rd];
  assign w_sof       = w_tag[1] && (r_beat_idx == '0);
  assign w_eof       = w_tag[0] && w_beat_last;

  assign w_inc = w_accept  ? c_CNT_W'(BURST_LEN) : '0;
  assign w_dec = w_beat_ok ? c_CNT_W'(1) : '0;

  assign w_buf_empty = r_level == '0;
  assign w_buf_full  = r_level == c_CNT_W'(OUT_DEPTH);
  assign w_wr        = w_beat_ok && !w_buf_full;
  assign w_rd        = !w_buf_empty && bus.out_ready;

  always_ff @(posedge ddr3clk) begin
    if (ddr3clk_reset) begin
      r_outstanding <= '0;
      r_level       <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_buf_wr      <= '0;
      r_buf_rd      <= '0;
      r_beat_idx    <= '0;
    end else begin
      r_outstanding <= r_outstanding + w_inc - w_dec;
      r_level       <= r_level + (w_wr ? c_CNT_W'(1) : '0) - (w_rd ? c_CNT_W'(1) : '0);
      if (w_accept)
        r_tag_wr <= r_tag_wr + c_PTR_W'(1);
      if (w_beat_ok) begin
        if (w_beat_last) begin
          r_beat_idx <= '0;
          r_tag_rd   <= r_tag_rd + c_PTR_W'(1);
        end else begin
          r_beat_idx <= r_beat_idx + c_BIDX_W'(1);
        end
      end
      if (w_wr)
        r_buf_wr <= r_buf_wr + c_PTR_W'(1);
      if (w_rd)
        r_buf_rd <= r_buf_rd + c_PTR_W'(1);
    end
  end

  // Storage arrays carry no reset; the pointers define their contents.
  always_ff @(posedge ddr3clk) begin
    if (w_accept)
      r_tag_mem[r_tag_wr] <= w_tag_new;
    if (w_wr)
      r_buf_mem[r_buf_wr] <= {bus.ddr3_readdata, w_tag[c_TAG_W-1:2], w_sof, w_eof};
  end

  // ---------------------------------------------------------------- output
  assign w_head        = r_buf_mem[r_buf_rd];
  assign bus.out_data  = w_head[c_BUF_W-1 -: DATA_W];
  assign bus.out_cam   = w_head[c_CAM_W+1:2];
  assign bus.out_sof   = w_head[1];
  assign bus.out_eof   = w_head[0];
  assign bus.out_valid = !w_buf_empty;

  assign busy = (r_state != ST_IDLE) || (r_outstanding != '0) || !w_buf_empty;

`ifdef DDR3_STRIP_READER_ERRCHK_EN
  logic [1:0] r_err;
  always_ff @(posedge ddr3clk) begin
    if (ddr3clk_reset) begin
      r_err <= '0;
    end else begin
      if (bus.ddr3_readdatavalid && (r_outstanding == '0))
        r_err[0] <= 1'b1;
      if ((r_state == ST_IDLE) && w_cmd_fire && w_cmd_bad)
        r_err[1] <= 1'b1;
    end
  end
  assign err_flags = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_strip_reader_multicam.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_strip_reader_multicam
// Description : Self-checking bench. Instance A: FRAME_LINES=4, BURST_LEN=1,
//               OUT_DEPTH=64. Instance B: FRAME_LINES=4, BURST_LEN=2,
//               OUT_DEPTH=8 for backpressure. Memory returns addr as data
//               with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_strip_reader_multicam;

  typedef struct {
    logic [26:0] addr;
    logic        cam;
    logic        sof;
    logic        eof;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    logic         cam;
    logic         sof;
    logic         eof;
    int           cyc;
  } beat_t;

  logic clk;
  logic rst_a, rst_b;
  logic busy_a, busy_b;
`ifdef DDR3_STRIP_READER_ERRCHK_EN
  logic [1:0] err_a, err_b;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_a = 0, acc_b = 0;
  int hold_a = 0;
  logic [26:0] qa[$], qb[$], req_a[$];
  int acc_cyc_a[$];
  beat_t out_a[$], out_b[$];
  vec_t tbl[16];

  ddr3_strip_reader_multicam_if #(.DATA_W(256), .ADDR_W(27), .NUM_CAMS(2), .MAX_COLS(32)) ia ();
  ddr3_strip_reader_multicam_if #(.DATA_W(256), .ADDR_W(27), .NUM_CAMS(2), .MAX_COLS(32)) ib ();

  ddr3_strip_reader_multicam #(.FRAME_LINES(4), .BURST_LEN(1), .OUT_DEPTH(64)) dut_a (
    .ddr3clk(clk), .ddr3clk_reset(rst_a), .bus(ia.master), .busy(busy_a)
`ifdef DDR3_STRIP_READER_ERRCHK_EN
    , .err_flags(err_a)
`endif
  );

  ddr3_strip_reader_multicam #(.FRAME_LINES(4), .BURST_LEN(2), .OUT_DEPTH(8)) dut_b (
    .ddr3clk(clk), .ddr3clk_reset(rst_b), .bus(ib.master), .busy(busy_b)
`ifdef DDR3_STRIP_READER_ERRCHK_EN
    , .err_flags(err_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Memory model and monitor for A.
  always @(posedge clk) begin
    beat_t b;
    cyc = cyc + 1;
    if (!rst_a && ia.ddr3_read && !ia.ddr3_waitrequest) begin
      qa.push_back(ia.ddr3_address);
      req_a.push_back(ia.ddr3_address);
      acc_cyc_a.push_back(cyc);
      acc_a = acc_a + 1;
    end
    if (!rst_a && ia.out_valid && ia.out_ready) begin
      b.data = ia.out_data; b.cam = ia.out_cam; b.sof = ia.out_sof;
      b.eof = ia.out_eof; b.cyc = cyc;
      out_a.push_back(b);
    end
    #1;
    if (hold_a == 0 && qa.size() > 0) begin
      ia.ddr3_readdatavalid = 1'b1;
      ia.ddr3_readdata = 256'(qa.pop_front());
    end else begin
      ia.ddr3_readdatavalid = 1'b0;
      ia.ddr3_readdata = '0;
    end
  end

  // Memory model and monitor for B (two-beat bursts).
  always @(posedge clk) begin
    beat_t b;
    if (!rst_b && ib.ddr3_read && !ib.ddr3_waitrequest) begin
      qb.push_back(ib.ddr3_address);
      qb.push_back(ib.ddr3_address + 27'd1);
      acc_b = acc_b + 1;
    end
    if (!rst_b && ib.out_valid && ib.out_ready) begin
      b.data = ib.out_data; b.cam = ib.out_cam; b.sof = ib.out_sof;
      b.eof = ib.out_eof; b.cyc = 0;
      out_b.push_back(b);
    end
    #1;
    if (qb.size() > 0) begin
      ib.ddr3_readdatavalid = 1'b1;
      ib.ddr3_readdata = 256'(qb.pop_front());
    end else begin
      ib.ddr3_readdatavalid = 1'b0;
      ib.ddr3_readdata = '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_a();
    req_a.delete(); out_a.delete(); acc_cyc_a.delete(); acc_a = 0;
  endtask

  task automatic cmd_a(input logic [26:0] addr, input logic [5:0] cols,
                       input logic [1:0] cams, input logic [26:0] stride);
    @(negedge clk);
    ia.start_addr = addr; ia.start_cols = cols; ia.start_cams = cams;
    ia.start_cam_stride = stride; ia.start_valid = 1'b1;
    @(negedge clk);
    ia.start_valid = 1'b0;
  endtask

  task automatic wait_out_a(input int n);
    int k = 0;
    while (out_a.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("out_a_count", 64'(out_a.size()), 64'(n));
  endtask

  task automatic cmp_run(input string nm, input int base, input int n);
    chk({nm, "_nreq"}, 64'(req_a.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < req_a.size() && i < out_a.size()) begin
        chk($sformatf("%s_addr%0d", nm, i), 64'(req_a[i]), 64'(tbl[base+i].addr));
        chk($sformatf("%s_data%0d", nm, i), out_a[i].data[63:0], 64'(tbl[base+i].addr));
        chk($sformatf("%s_cam%0d", nm, i), 64'(out_a[i].cam), 64'(tbl[base+i].cam));
        chk($sformatf("%s_sof%0d", nm, i), 64'(out_a[i].sof), 64'(tbl[base+i].sof));
        chk($sformatf("%s_eof%0d", nm, i), 64'(out_a[i].eof), 64'(tbl[base+i].eof));
      end
    end
  endtask

  initial begin
    int k;
    int saw;
    logic [26:0] ea;
    // single camera, 2 columns
    tbl[0]  = '{27'h100, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{27'h130, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{27'h160, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{27'h190, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{27'h101, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{27'h131, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{27'h161, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{27'h191, 1'b0, 1'b0, 1'b1};
    // two cameras, 1 column, stride 0x4000
    tbl[8]  = '{27'h100, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{27'h130, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{27'h160, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{27'h190, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{27'h4100, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{27'h4130, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{27'h4160, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{27'h4190, 1'b1, 1'b0, 1'b1};

    rst_a = 1'b1; rst_b = 1'b1;
    ia.start_addr = '0; ia.start_cols = '0; ia.start_cams = '0;
    ia.start_cam_stride = '0; ia.start_valid = 1'b0;
    ia.ddr3_waitrequest = 1'b0; ia.out_ready = 1'b1;
    ib.start_addr = '0; ib.start_cols = '0; ib.start_cams = '0;
    ib.start_cam_stride = '0; ib.start_valid = 1'b0;
    ib.ddr3_waitrequest = 1'b0; ib.out_ready = 1'b0;
    ia.ddr3_readdatavalid = 1'b0; ia.ddr3_readdata = '0;
    ib.ddr3_readdatavalid = 1'b0; ib.ddr3_readdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", 64'(ia.start_ready), 64'd0);
    chk("rst_read", 64'(ia.ddr3_read), 64'd0);
    chk("rst_addr", 64'(ia.ddr3_address), 64'd0);
    chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("post_rst_start_ready", 64'(ia.start_ready), 64'd1);

    // Single camera, no stalls.
    clear_a();
    cmd_a(27'h100, 6'd2, 2'd1, 27'h0);
    ia.start_valid = 1'b1; ia.start_addr = 27'h5000;
    chk("busy_start_ready", 64'(ia.start_ready), 64'd0);
    @(negedge clk);
    ia.start_valid = 1'b0;
    wait_out_a(8);
    @(negedge clk);
    chk("idle_start_ready", 64'(ia.start_ready), 64'd1);
    chk("idle_busy", 64'(busy_a), 64'd0);
    cmp_run("single", 0, 8);
    if (acc_cyc_a.size() == 8 && out_a.size() == 8) begin
      chk("issue_rate", 64'(acc_cyc_a[7] - acc_cyc_a[0]), 64'd7);
      chk("out_rate", 64'(out_a[7].cyc - out_a[0].cyc), 64'd7);
      chk("latency", 64'(out_a[0].cyc - acc_cyc_a[0]), 64'd2);
    end else begin
      chk("rate_sizes", 64'(acc_cyc_a.size()), 64'd8);
    end

    // Two cameras.
    clear_a();
    cmd_a(27'h100, 6'd1, 2'd2, 27'h4000);
    wait_out_a(8);
    @(negedge clk);
    cmp_run("twocam", 8, 8);

    // Waitrequest held on the third request.
    clear_a();
    cmd_a(27'h100, 6'd1, 2'd1, 27'h0);
    k = 0;
    while (acc_a < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("wr_pre_acc", 64'(acc_a), 64'd2);
    ia.ddr3_waitrequest = 1'b1;
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("wr_addr%0d", s), 64'(ia.ddr3_address), 64'h160);
      chk($sformatf("wr_read%0d", s), 64'(ia.ddr3_read), 64'd1);
      @(negedge clk);
    end
    ia.ddr3_waitrequest = 1'b0;
    wait_out_a(4);
    repeat (3) @(negedge clk);
    cmp_run("wreq", 8, 4);

    // start_cols=0 behaves as one column.
    clear_a();
    cmd_a(27'h100, 6'd0, 2'd1, 27'h0);
    wait_out_a(4);
    repeat (3) @(negedge clk);
    cmp_run("cols0", 8, 4);

`ifdef DDR3_STRIP_READER_ERRCHK_EN
    clear_a();
    cmd_a(27'h100, 6'd33, 2'd1, 27'h0);
    chk("bad_busy", 64'(busy_a), 64'd0);
    chk("bad_ready", 64'(ia.start_ready), 64'd1);
    chk("bad_err1", 64'(err_a[1]), 64'd1);
    repeat (3) @(negedge clk);
    chk("bad_nreq", 64'(req_a.size()), 64'd0);
`endif

    // Reset mid-operation with stray beats afterwards.
    clear_a();
    hold_a = 1;
    cmd_a(27'h100, 6'd2, 2'd1, 27'h0);
    k = 0;
    while (acc_a < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mid_acc", 64'(acc_a), 64'd3);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    hold_a = 0;
    saw = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (ia.out_valid) saw = 1;
    end
    chk("mid_no_out_valid", 64'(saw), 64'd0);
    chk("mid_busy", 64'(busy_a), 64'd0);
    chk("mid_start_ready", 64'(ia.start_ready), 64'd1);
`ifdef DDR3_STRIP_READER_ERRCHK_EN
    chk("mid_err0", 64'(err_a[0]), 64'd1);
`endif

    // Backpressure on B: credit allows 4 bursts (8 beats) into an 8-deep buffer.
    @(negedge clk);
    ib.start_addr = 27'h100; ib.start_cols = 6'd2; ib.start_cams = 2'd1;
    ib.start_cam_stride = '0; ib.start_valid = 1'b1;
    @(negedge clk);
    ib.start_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("bp_acc_stall", 64'(acc_b), 64'd4);
    chk("bp_valid", 64'(ib.out_valid), 64'd1);
    chk("bp_head", ib.out_data[63:0], 64'h100);
    chk("bp_head_sof", 64'(ib.out_sof), 64'd1);
    ib.out_ready = 1'b1;
    k = 0;
    while (out_b.size() < 16 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("bp_nbeats", 64'(out_b.size()), 64'd16);
    chk("bp_acc_total", 64'(acc_b), 64'd8);
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 2; j++) begin
        ea = 27'h100 + 27'((r / 4) * 2) + 27'((r % 4) * 48) + 27'(j);
        if (r * 2 + j < out_b.size()) begin
          chk($sformatf("bp_data%0d", r * 2 + j), out_b[r*2+j].data[63:0], 64'(ea));
          chk($sformatf("bp_sof%0d", r * 2 + j), 64'(out_b[r*2+j].sof), 64'(r == 0 && j == 0));
          chk($sformatf("bp_eof%0d", r * 2 + j), 64'(out_b[r*2+j].eof), 64'(r == 7 && j == 1));
        end
      end
    end
    repeat (3) @(negedge clk);
    chk("bp_idle", 64'(busy_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
